// File: rtl/lsu_word_adapter_if.sv
// rtl/lsu_word_adapter_if.sv - request/response and RAM bus bundle for lsu_word_adapter
//
// Signals:
//   req_*        execute-stage request (valid/ready handshake)
//   resp_*       response back to the execute stage (valid/ready handshake)
//   ram_*        single-cycle word access towards the RAM black box
// Modports:
//   slave        the adapter: takes requests, returns responses, drives the RAM
//   master       the surroundings: execute stage plus RAM read-data return
interface lsu_word_adapter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_wen;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  logic                  ram_valid;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_wen;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  req_valid, req_addr, req_wen, req_size, req_unsigned, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output ram_valid, ram_addr, ram_wen, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output req_valid, req_addr, req_wen, req_size, req_unsigned, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  ram_valid, ram_addr, ram_wen, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/lsu_word_adapter.sv
// rtl/lsu_word_adapter.sv - byte/half/word load-store adapter onto a word-addressed RAM
//
// Ports:
//   clock        single clock, all state on posedge
//   reset        synchronous, active-high; forces IDLE and clears all registers
//   bus          lsu_word_adapter_if.slave
//                  req_*  : byte address, store/load, size (0 byte, 1 half, 2 word),
//                           unsigned flag, right-aligned store data
//                  resp_* : extended load data (0 for stores/errors), error flag
//                  ram_*  : word-aligned access, one cycle per RD or WR state
module lsu_word_adapter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic               clock,
  input logic               reset,
  lsu_word_adapter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  state_t                state;

  // Request captured at accept; req_* are ignored for the rest of the operation.
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wen_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  // RAM word read during RD; source for both load extraction and the RMW merge.
  logic [DATA_WIDTH-1:0] word_q;

  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic                  ram_valid_q;
  logic                  ram_wen_q;

  logic                  req_misaligned;
  logic                  req_word_store;

  // Write-back word: lane replacement into the fetched word, or the whole
  // store data for a word store (word_q is then unused).
  function automatic logic [DATA_WIDTH-1:0] merge_word(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_data,
    input logic [1:0]            size,
    input logic [1:0]            lane
  );
    logic [DATA_WIDTH-1:0] w;
    w = old_word;
    case (size)
      SIZE_BYTE: w[{lane, 3'b000} +: 8]     = new_data[7:0];
      SIZE_HALF: w[{lane[1], 4'b0000} +: 16] = new_data[15:0];
      default:   w = new_data;
    endcase
    return w;
  endfunction

  // Pick the addressed lane out of the fetched word and extend it.
  function automatic logic [DATA_WIDTH-1:0] extract_load(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            size,
    input logic [1:0]            lane,
    input logic                  is_unsigned
  );
    logic [7:0]            b;
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SIZE_BYTE: r = {{24{~is_unsigned & b[7]}}, b};
      SIZE_HALF: r = {{16{~is_unsigned & h[15]}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

  // Size 3 never reaches the RAM; it is reported exactly like a misaligned access.
  always_comb begin
    req_misaligned = 1'b0;
    case (bus.req_size)
      SIZE_BYTE: req_misaligned = 1'b0;
      SIZE_HALF: req_misaligned = bus.req_addr[0];
      SIZE_WORD: req_misaligned = |bus.req_addr[1:0];
      default:   req_misaligned = 1'b1;
    endcase
  end

  // Only a whole-word store can skip the read; sub-word stores need the old word.
  assign req_word_store = bus.req_wen && (bus.req_size == SIZE_WORD);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      size_q       <= 2'd0;
      unsigned_q   <= 1'b0;
      wdata_q      <= '0;
      word_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      ram_valid_q  <= 1'b0;
      ram_wen_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            addr_q     <= bus.req_addr;
            wen_q      <= bus.req_wen;
            size_q     <= bus.req_size;
            unsigned_q <= bus.req_unsigned;
            wdata_q    <= bus.req_wdata;
            if (req_misaligned) begin
              state        <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (req_word_store) begin
              state       <= S_WR;
              ram_valid_q <= 1'b1;
              ram_wen_q   <= 1'b1;
            end else begin
              state       <= S_RD;
              ram_valid_q <= 1'b1;
              ram_wen_q   <= 1'b0;
            end
          end
        end

        S_RD: begin
          // ram_rdata settled after the RAM's negedge update; safe to sample here.
          word_q <= bus.ram_rdata;
          if (wen_q) begin
            state     <= S_WR;
            ram_wen_q <= 1'b1;
          end else begin
            state        <= S_RESP;
            ram_valid_q  <= 1'b0;
            resp_valid_q <= 1'b1;
          end
        end

        S_WR: begin
          state        <= S_RESP;
          ram_valid_q  <= 1'b0;
          ram_wen_q    <= 1'b0;
          resp_valid_q <= 1'b1;
        end

        S_RESP: begin
          if (bus.resp_ready) begin
            state        <= S_IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
          end
        end

        default: begin
          state        <= S_IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          ram_valid_q  <= 1'b0;
          ram_wen_q    <= 1'b0;
        end
      endcase
    end
  end

  // req_ready is forced low during reset even though state may not yet be IDLE.
  assign bus.req_ready  = (state == S_IDLE) && !reset;

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  // Held stable through backpressure because word_q and the *_q fields only
  // change on accept or in RD.
  assign bus.resp_rdata = (state == S_RESP && !resp_err_q && !wen_q)
                          ? extract_load(word_q, size_q, addr_q[1:0], unsigned_q)
                          : '0;

  assign bus.ram_valid  = ram_valid_q;
  assign bus.ram_wen    = ram_wen_q;
  assign bus.ram_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign bus.ram_wdata  = (state == S_WR)
                          ? merge_word(word_q, wdata_q, size_q, addr_q[1:0])
                          : '0;

endmodule
